// File: rtl/simon_pkg.sv
// Shared types, constants and rotate helpers for the Simon32/64 round sequencer.
package simon_pkg;

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned BLOCK_W    = 32;
  localparam int unsigned RND_W      = 6;
  localparam int unsigned MAX_ROUNDS = 62;

  typedef logic [WORD_W-1:0] word_t;

  // Block payload: x is the upper half, y the lower half.
  typedef struct packed {
    word_t x;
    word_t y;
  } block_t;

  // Key payload: k0 is the first round key.
  typedef struct packed {
    word_t k3;
    word_t k2;
    word_t k1;
    word_t k0;
  } key_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // z0 sequence; element i sits at bit (61 - i).
  localparam logic [MAX_ROUNDS-1:0] Z0 =
    62'b11111010001001010110000111001101111101000100101011000011100110;

  // Round constant 2^16 - 4.
  localparam word_t C = 16'hFFFC;

  function automatic word_t rol(input word_t a, input int unsigned s);
    return (a << s) | (a >> (WORD_W - s));
  endfunction

  function automatic word_t ror(input word_t a, input int unsigned s);
    return (a >> s) | (a << (WORD_W - s));
  endfunction

  // z0 element for round i (i <= 61).
  function automatic logic z0_bit(input logic [RND_W-1:0] i);
    return Z0[RND_W'(MAX_ROUNDS - 1) - i];
  endfunction

endpackage

// File: rtl/simon32_round_sched_if.sv
// Request/response bus between the block-level requester and the round sequencer.
interface simon32_round_sched_if;
  import simon_pkg::*;

  logic   in_valid;
  logic   in_ready;
  block_t pt;
  key_t   key;
  logic   out_valid;
  logic   out_ready;
  block_t ct;
  logic   busy;

  modport master (
    output in_valid, pt, key, out_ready,
    input  in_ready, out_valid, ct, busy
  );

  modport slave (
    input  in_valid, pt, key, out_ready,
    output in_ready, out_valid, ct, busy
  );

endinterface

// File: rtl/simon32_round.sv
// One Simon32 Feistel round: x' = y ^ f(x) ^ rk, y' = x.
module simon32_round
  import simon_pkg::*;
(
  input  word_t x_i,
  input  word_t y_i,
  input  word_t rk_i,
  output word_t x_c,
  output word_t y_c
);

  // Round function on the current half-block pair.
  always_comb begin
    x_c = y_i ^ ((rol(x_i, 1) & rol(x_i, 8)) ^ rol(x_i, 2)) ^ rk_i;
    y_c = x_i;
  end

endmodule

// File: rtl/simon32_round_sched.sv
// Iterative Simon32/64 encryptor: accepts a block, runs one round per cycle
// with an on-the-fly key schedule, then holds the ciphertext until taken.
module simon32_round_sched
  import simon_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  simon32_round_sched_if.slave   bus
);

  if (NUM_ROUNDS < 1 || NUM_ROUNDS > MAX_ROUNDS) begin : g_bad_rounds
    $error("simon32_round_sched: NUM_ROUNDS must be in 1..62");
  end

  if ($bits(block_t) != BLOCK_W) begin : g_bad_block
    $error("simon32_round_sched: block_t width mismatch");
  end

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS - 1);

  state_t            state_q, state_d;
  logic [RND_W-1:0]  rnd_q, rnd_d;
  word_t             x_q, x_d;
  word_t             y_q, y_d;
  word_t [3:0]       kw_q, kw_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;

  word_t             rx_c, ry_c;
  word_t             ks_tmp_c;
  word_t             kw_new_c;

  simon32_round u_round (
    .x_i  (x_q),
    .y_i  (y_q),
    .rk_i (kw_q[0]),
    .x_c  (rx_c),
    .y_c  (ry_c)
  );

  // Next key word for the sliding four-word window.
  always_comb begin
    ks_tmp_c = ror(kw_q[3], 3) ^ kw_q[1];
    ks_tmp_c = ks_tmp_c ^ ror(ks_tmp_c, 1);
    kw_new_c = C ^ kw_q[0] ^ ks_tmp_c ^ WORD_W'(z0_bit(rnd_q));
  end

  // Next-state and registered-output logic for IDLE/RUN/DONE.
  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    x_d         = x_q;
    y_d         = y_q;
    kw_d        = kw_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          x_d        = bus.pt.x;
          y_d        = bus.pt.y;
          kw_d       = {bus.key.k3, bus.key.k2, bus.key.k1, bus.key.k0};
          rnd_d      = '0;
          state_d    = RUN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      RUN: begin
        x_d   = rx_c;
        y_d   = ry_c;
        kw_d  = {kw_new_c, kw_q[3], kw_q[2], kw_q[1]};
        rnd_d = rnd_q + RND_W'(1);
        if (rnd_q == LAST_RND) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rnd_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      kw_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      x_q         <= x_d;
      y_q         <= y_d;
      kw_q        <= kw_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.ct        = {x_q, y_q};

endmodule

// File: tb/tb_simon32_round_sched.sv
// Self-checking bench for simon32_round_sched (32-round and 1-round instances).
module tb_simon32_round_sched;

  logic clk;
  logic reset;
  int   checks;
  int   passed;
  int   cyc;

  localparam logic [31:0] KAT_PT  = 32'h6565_6877;
  localparam logic [63:0] KAT_KEY = 64'h1918_1110_0908_0100;
  localparam logic [31:0] KAT_CT  = 32'hc69b_e9bb;

  simon32_round_sched_if i32 ();
  simon32_round_sched_if i1 ();

  simon32_round_sched #(.NUM_ROUNDS(32)) u_dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (i32.slave)
  );

  simon32_round_sched #(.NUM_ROUNDS(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (i1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cipher: full key schedule in an array, then plain rounds.
  function automatic logic [15:0] brol(input logic [15:0] a, input int s);
    return (a << s) | (a >> (16 - s));
  endfunction

  function automatic logic [15:0] bror(input logic [15:0] a, input int s);
    return (a >> s) | (a << (16 - s));
  endfunction

  function automatic logic [31:0] model_enc(input logic [31:0] p, input logic [63:0] k, input int n);
    logic [61:0] zs;
    logic [15:0] ks [0:65];
    logic [15:0] x, y, t;
    zs = 62'b11111010001001010110000111001101111101000100101011000011100110;
    ks[0] = k[15:0];
    ks[1] = k[31:16];
    ks[2] = k[47:32];
    ks[3] = k[63:48];
    for (int i = 0; i < 62; i++) begin
      t = bror(ks[i+3], 3) ^ ks[i+1];
      ks[i+4] = 16'hfffc ^ {15'b0, zs[61-i]} ^ ks[i] ^ t ^ bror(t, 1);
    end
    x = p[31:16];
    y = p[15:0];
    for (int i = 0; i < n; i++) begin
      t = x;
      x = y ^ ((brol(x, 1) & brol(x, 8)) ^ brol(x, 2)) ^ ks[i];
      y = t;
    end
    return {x, y};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected ciphertexts of blocks accepted by the 32-round instance.
  logic [31:0] exp_q[$];

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (i32.out_valid && i32.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (i32.in_valid && i32.in_ready) exp_q.push_back(model_enc(i32.pt, i32.key, 32));
    end
  end

  // Every cycle the ciphertext is presented it must match the model.
  always @(negedge clk) begin
    if (!reset && i32.out_valid) begin
      checks++;
      if (exp_q.size() > 0 && i32.ct === exp_q[0]) passed++;
      else $display("FAIL ct_model: got %h expected %h (pending %0d)", i32.ct,
                    (exp_q.size() > 0) ? exp_q[0] : 32'h0, exp_q.size());
    end
  end

  task automatic send32(input logic [31:0] p, input logic [63:0] k);
    chk("in_ready_before_accept", 64'(i32.in_ready), 64'd1);
    i32.pt       = p;
    i32.key      = k;
    i32.in_valid = 1'b1;
    tick();
    i32.in_valid = 1'b0;
  endtask

  task automatic wait_valid32(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!i32.out_valid && n < 200);
  endtask

  initial begin
    int n;
    int k;
    int acc[$];
    logic [31:0] bp [3];
    logic [63:0] bk [3];
    logic will_acc;

    checks = 0;
    passed = 0;
    cyc    = 0;
    reset  = 1'b1;
    i32.in_valid = 1'b0; i32.out_ready = 1'b1; i32.pt = '0; i32.key = '0;
    i1.in_valid  = 1'b0; i1.out_ready  = 1'b1; i1.pt  = '0; i1.key  = '0;

    chk("model_kat", 64'(model_enc(KAT_PT, KAT_KEY, 32)), 64'(KAT_CT));
    chk("model_1rnd", 64'(model_enc(32'h0001_0000, 64'h0, 1)), 64'h0000_0000_0004_0001);

    // Reset state.
    repeat (2) tick();
    chk("rst_in_ready", 64'(i32.in_ready), 64'd1);
    chk("rst_out_valid", 64'(i32.out_valid), 64'd0);
    chk("rst_ct", 64'(i32.ct), 64'd0);
    chk("rst_busy", 64'(i32.busy), 64'd0);
    chk("rst1_in_ready", 64'(i1.in_ready), 64'd1);
    reset = 1'b0;
    tick();

    // Known-answer block with latency check.
    send32(KAT_PT, KAT_KEY);
    chk("run_in_ready", 64'(i32.in_ready), 64'd0);
    chk("run_busy", 64'(i32.busy), 64'd1);
    wait_valid32(n);
    chk("kat_latency", 64'(n), 64'd32);
    chk("kat_ct", 64'(i32.ct), 64'(KAT_CT));
    tick();
    chk("kat_out_valid_drop", 64'(i32.out_valid), 64'd0);
    chk("kat_in_ready_back", 64'(i32.in_ready), 64'd1);
    chk("kat_busy_drop", 64'(i32.busy), 64'd0);

    // Backpressure: result held while the consumer stalls.
    i32.out_ready = 1'b0;
    send32(KAT_PT, KAT_KEY);
    wait_valid32(n);
    chk("bp_latency", 64'(n), 64'd32);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_out_valid", 64'(i32.out_valid), 64'd1);
      chk("bp_ct", 64'(i32.ct), 64'(KAT_CT));
      chk("bp_in_ready", 64'(i32.in_ready), 64'd0);
      chk("bp_busy", 64'(i32.busy), 64'd1);
    end
    i32.out_ready = 1'b1;
    tick();
    chk("bp_out_valid_drop", 64'(i32.out_valid), 64'd0);
    chk("bp_in_ready_back", 64'(i32.in_ready), 64'd1);
    chk("bp_single_transfer", 64'(exp_q.size()), 64'd0);

    // Input pulses during RUN are ignored.
    send32(KAT_PT, KAT_KEY);
    repeat (4) tick();
    i32.pt = 32'hdead_beef; i32.key = 64'h0123_4567_89ab_cdef; i32.in_valid = 1'b1;
    repeat (3) tick();
    i32.in_valid = 1'b0;
    wait_valid32(n);
    chk("ign_ct", 64'(i32.ct), 64'(KAT_CT));
    tick();

    // Reset in the middle of RUN.
    send32(KAT_PT, KAT_KEY);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_in_ready", 64'(i32.in_ready), 64'd1);
    chk("mid_rst_out_valid", 64'(i32.out_valid), 64'd0);
    chk("mid_rst_ct", 64'(i32.ct), 64'd0);
    chk("mid_rst_busy", 64'(i32.busy), 64'd0);
    send32(KAT_PT, KAT_KEY);
    wait_valid32(n);
    chk("post_rst_ct", 64'(i32.ct), 64'(KAT_CT));
    tick();

    // Back-to-back random blocks with in_valid and out_ready held high.
    for (int i = 0; i < 3; i++) begin
      bp[i] = $urandom();
      bk[i] = {$urandom(), $urandom()};
    end
    k = 0;
    n = 0;
    i32.pt = bp[0]; i32.key = bk[0]; i32.in_valid = 1'b1;
    while (k < 3 && n < 400) begin
      will_acc = i32.in_ready;
      tick();
      n++;
      if (will_acc) begin
        acc.push_back(cyc);
        k++;
        if (k < 3) begin
          i32.pt = bp[k]; i32.key = bk[k];
        end else begin
          i32.in_valid = 1'b0;
        end
      end
    end
    chk("b2b_accepts", 64'(k), 64'd3);
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("b2b_drain", 64'(exp_q.size()), 64'd0);
    if (acc.size() == 3) begin
      chk("b2b_spacing0", 64'(acc[1] - acc[0]), 64'd34);
      chk("b2b_spacing1", 64'(acc[2] - acc[1]), 64'd34);
    end else begin
      chk("b2b_spacing_count", 64'(acc.size()), 64'd3);
    end

    // Single-round instance.
    i1.pt = 32'h0001_0000; i1.key = 64'h0; i1.in_valid = 1'b1;
    tick();
    i1.in_valid = 1'b0;
    chk("r1_busy", 64'(i1.busy), 64'd1);
    n = 0;
    do begin
      tick();
      n++;
    end while (!i1.out_valid && n < 20);
    chk("r1_latency", 64'(n), 64'd1);
    chk("r1_ct", 64'(i1.ct), 64'h0000_0000_0004_0001);
    tick();
    chk("r1_in_ready_back", 64'(i1.in_ready), 64'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
